ifu_fetch_ctrl: RTL and testbench

IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

---
 rtl/ifu_fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// ifu_fetch_ctrl
// Instruction fetch controller. It issues one word-aligned request at a time
// to instruction memory, presents each returned word to decode with its PC,
// and handles branch/jump redirects by discarding responses to stale requests.
//
// Ports
//   sys_clk        : clock, all state on the rising edge
//   sys_rst        : asynchronous, active-low reset
//   redirect_valid : redirect request from branch/jump resolution
//   redirect_pc    : redirect target (low two bits ignored)
//   imem_req       : instruction memory request
//   imem_addr      : request address, held until imem_ack
//   imem_ack       : memory response, only honoured while imem_req=1
//   imem_rdata     : instruction word, valid with imem_ack
//   out_valid      : instruction available to decode
//   out_ready      : decode accepts the instruction
//   out_pc         : PC of the presented instruction
//   out_pc_plus_4  : out_pc + 4
//   out_inst       : presented instruction word
//   drop_cnt       : saturating count of discarded memory responses
// ---------------------------------------------------------------------------
module ifu_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h80000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [63:0] out_pc_plus_4,
  output logic [31:0] out_inst,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      state, state_nxt;
  logic [63:0] fetch_pc, fetch_pc_nxt;
  logic [63:0] pend_pc, pend_pc_nxt;
  logic [63:0] out_pc_nxt, out_pc_plus_4_nxt;
  logic [31:0] out_inst_nxt;
  logic [15:0] drop_cnt_nxt;

  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ~64'h3;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Request and valid are pure state decodes, so reset clears them at once
  // and the address cannot move while a request is outstanding.
  assign imem_req  = (state == FETCH) || (state == DROP);
  assign imem_addr = fetch_pc;
  assign out_valid = (state == HOLD);

  always_comb begin
    state_nxt         = state;
    fetch_pc_nxt      = fetch_pc;
    pend_pc_nxt       = pend_pc;
    out_pc_nxt        = out_pc;
    out_pc_plus_4_nxt = out_pc_plus_4;
    out_inst_nxt      = out_inst;
    drop_cnt_nxt      = drop_cnt;
    case (state)
      IDLE: begin
        if (redirect_valid) fetch_pc_nxt = align_pc(redirect_pc);
        state_nxt = FETCH;
      end
      FETCH: begin
        if (redirect_valid && imem_ack) begin
          // response belongs to the old path: drop it, refetch at once
          fetch_pc_nxt = align_pc(redirect_pc);
          drop_cnt_nxt = sat_inc(drop_cnt);
        end else if (redirect_valid) begin
          // request must stay on the bus until it is acked
          pend_pc_nxt = align_pc(redirect_pc);
          state_nxt   = DROP;
        end else if (imem_ack) begin
          out_pc_nxt        = fetch_pc;
          out_pc_plus_4_nxt = fetch_pc + 64'd4;
          out_inst_nxt      = imem_rdata;
          state_nxt         = HOLD;
        end
      end
      HOLD: begin
        // a redirect squashes the presented instruction even if accepted
        if (redirect_valid) begin
          fetch_pc_nxt = align_pc(redirect_pc);
          state_nxt    = FETCH;
        end else if (out_ready) begin
          fetch_pc_nxt = fetch_pc + 64'd4;
          state_nxt    = FETCH;
        end
      end
      DROP: begin
        if (imem_ack) begin
          drop_cnt_nxt = sat_inc(drop_cnt);
          fetch_pc_nxt = redirect_valid ? align_pc(redirect_pc) : pend_pc;
          state_nxt    = FETCH;
        end else if (redirect_valid) begin
          pend_pc_nxt = align_pc(redirect_pc);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      pend_pc       <= RESET_PC;
      out_pc        <= '0;
      out_pc_plus_4 <= '0;
      out_inst      <= '0;
      drop_cnt      <= '0;
    end else begin
      state         <= state_nxt;
      fetch_pc      <= fetch_pc_nxt;
      pend_pc       <= pend_pc_nxt;
      out_pc        <= out_pc_nxt;
      out_pc_plus_4 <= out_pc_plus_4_nxt;
      out_inst      <= out_inst_nxt;
      drop_cnt      <= drop_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
module tb_ifu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [63:0] out_pc_plus_4;
  logic [31:0] out_inst;
  logic [15:0] drop_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];

  ifu_fetch_ctrl #(.RESET_PC(64'h80000000)) dut (
    .sys_clk(clk), .sys_rst(sys_rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4), .out_inst(out_inst),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h13579BDF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    tick(); tick();
    sys_rst = 1'b1;
    tick();
  endtask

  // Memory responder: waits (bounded) for a request, then acks after lat cycles.
  task automatic serve_one(input int lat, output logic [63:0] addr, output bit ok);
    int n = 0;
    ok = 1'b1;
    addr = '0;
    while (imem_req !== 1'b1 && n < 20) begin tick(); n++; end
    if (imem_req !== 1'b1) begin
      ok = 1'b0;
    end else begin
      addr = imem_addr;
      repeat (lat) tick();
      imem_ack = 1'b1; imem_rdata = mem_word(addr);
      tick();
      imem_ack = 1'b0; imem_rdata = '0;
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (out_pc !== 64'h0 || out_pc_plus_4 !== 64'h0 || out_inst !== 32'h0)
      begin failures++; $display("FAIL rst_outs got=%h/%h/%h exp=0", out_pc, out_pc_plus_4, out_inst); end
    checks++; if (drop_cnt !== 16'h0) begin failures++; $display("FAIL rst_drop got=%h exp=0", drop_cnt); end
    // release with a redirect visible in IDLE, and a stray ack that must be ignored
    sys_rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h80000C02; imem_ack = 1'b1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req got=%b exp=0", imem_req); end
    tick();
    redirect_valid = 1'b0; imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h80000C00)
      begin failures++; $display("FAIL idle_redirect got=%b/%h exp=1/80000c00", imem_req, imem_addr); end
    checks++; if (out_valid !== 1'b0 || drop_cnt !== 16'h0)
      begin failures++; $display("FAIL idle_ack_ignored got=%b/%h exp=0/0", out_valid, drop_cnt); end
  endtask

  task automatic test_basic();
    logic [63:0] a, got, e;
    bit ok;
    int prev = 0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      e = 64'h80000000 + 64'(4 * k);
      exp_q.push_back(e);
      if (k > 0) begin
        checks++; if (cyc - prev != 3) begin failures++; $display("FAIL basic_rate got=%0d exp=3", cyc - prev); end
      end
      prev = cyc;
      serve_one(1, a, ok);
      checks++; if (!ok || a !== e) begin failures++; $display("FAIL basic_addr got=%h exp=%h", a, e); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
      got = exp_q.pop_front();
      checks++; if (out_pc !== got || out_pc_plus_4 !== got + 64'd4)
        begin failures++; $display("FAIL basic_pc got=%h/%h exp=%h", out_pc, out_pc_plus_4, got); end
      checks++; if (out_inst !== mem_word(got))
        begin failures++; $display("FAIL basic_inst got=%h exp=%h", out_inst, mem_word(got)); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      checks++; if (imem_req !== 1'b1 || out_valid !== 1'b0)
        begin failures++; $display("FAIL basic_refetch got=%b/%b exp=1/0", imem_req, out_valid); end
    end
  endtask

  task automatic test_stall();
    logic [63:0] a, got;
    bit ok;
    do_reset();
    serve_one(1, a, ok);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    exp_q.push_back(64'h80000004);
    serve_one(1, a, ok);
    got = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || imem_req !== 1'b0)
        begin failures++; $display("FAIL stall_ctrl got=%b/%b exp=1/0", out_valid, imem_req); end
      checks++; if (out_pc !== got || out_inst !== mem_word(got))
        begin failures++; $display("FAIL stall_data got=%h/%h exp=%h/%h", out_pc, out_inst, got, mem_word(got)); end
      tick();
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (imem_addr !== 64'h80000008)
      begin failures++; $display("FAIL stall_next got=%h exp=80000008", imem_addr); end
  endtask

  task automatic test_redirect_wait();
    logic [63:0] a, got;
    bit ok;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 64'h80000103;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h80000000 || out_valid !== 1'b0)
        begin failures++; $display("FAIL drop_hold got=%b/%h/%b exp=1/80000000/0", imem_req, imem_addr, out_valid); end
      if (i == 2) begin imem_ack = 1'b1; imem_rdata = mem_word(64'h80000000); end
      tick();
    end
    imem_ack = 1'b0;
    checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL drop_cnt got=%0d exp=1", drop_cnt); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h80000100 || out_valid !== 1'b0)
      begin failures++; $display("FAIL drop_next got=%b/%h/%b exp=1/80000100/0", imem_req, imem_addr, out_valid); end
    exp_q.push_back(64'h80000100);
    serve_one(1, a, ok);
    got = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || out_pc !== got || out_inst !== mem_word(got))
      begin failures++; $display("FAIL drop_target got=%b/%h/%h exp=1/%h/%h", out_valid, out_pc, out_inst, got, mem_word(got)); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_double_redirect();
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 64'h80000200; tick();
    redirect_pc = 64'h80000300; tick();
    redirect_valid = 1'b0;
    imem_ack = 1'b1; imem_rdata = mem_word(imem_addr); tick(); imem_ack = 1'b0;
    checks++; if (imem_addr !== 64'h80000300 || drop_cnt !== 16'd1)
      begin failures++; $display("FAIL latest_wins got=%h/%0d exp=80000300/1", imem_addr, drop_cnt); end
    // redirect together with ack in FETCH
    redirect_valid = 1'b1; redirect_pc = 64'h80000400; imem_ack = 1'b1; tick();
    imem_ack = 1'b0; redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h80000400 || drop_cnt !== 16'd2 || out_valid !== 1'b0)
      begin failures++; $display("FAIL fetch_redir_ack got=%b/%h/%0d/%b exp=1/80000400/2/0", imem_req, imem_addr, drop_cnt, out_valid); end
    // redirect into DROP, then a second redirect with ack
    redirect_valid = 1'b1; redirect_pc = 64'h80000500; tick();
    redirect_pc = 64'h80000601; imem_ack = 1'b1; tick();
    imem_ack = 1'b0; redirect_valid = 1'b0;
    checks++; if (imem_addr !== 64'h80000600 || drop_cnt !== 16'd3)
      begin failures++; $display("FAIL drop_redir_ack got=%h/%0d exp=80000600/3", imem_addr, drop_cnt); end
  endtask

  task automatic test_hold_redirect();
    logic [63:0] a, got;
    bit ok;
    do_reset();
    exp_q.push_back(64'h80000000);
    serve_one(1, a, ok);
    got = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || out_pc !== got)
      begin failures++; $display("FAIL hold_pre got=%b/%h exp=1/%h", out_valid, out_pc, got); end
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h80000800; tick();
    out_ready = 1'b0; redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h80000800)
      begin failures++; $display("FAIL hold_redirect got=%b/%b/%h exp=0/1/80000800", out_valid, imem_req, imem_addr); end
  endtask

  task automatic test_wrap_and_reset();
    logic [63:0] a, got;
    bit ok;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 64'hFFFFFFFFFFFFFFFF; imem_ack = 1'b1; tick();
    redirect_valid = 1'b0; imem_ack = 1'b0;
    checks++; if (imem_addr !== 64'hFFFFFFFFFFFFFFFC)
      begin failures++; $display("FAIL wrap_align got=%h exp=fffffffffffffffc", imem_addr); end
    exp_q.push_back(64'hFFFFFFFFFFFFFFFC);
    serve_one(1, a, ok);
    got = exp_q.pop_front();
    checks++; if (out_pc !== got || out_pc_plus_4 !== 64'h0)
      begin failures++; $display("FAIL wrap_plus4 got=%h/%h exp=%h/0", out_pc, out_pc_plus_4, got); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0)
      begin failures++; $display("FAIL wrap_next got=%b/%h exp=1/0", imem_req, imem_addr); end
    tick();
    sys_rst = 1'b0; #1;
    checks++; if (imem_req !== 1'b0 || out_valid !== 1'b0)
      begin failures++; $display("FAIL async_rst got=%b/%b exp=0/0", imem_req, out_valid); end
    tick();
    sys_rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEADDEAD; tick();
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h80000000 || out_valid !== 1'b0 || drop_cnt !== 16'h0)
      begin failures++; $display("FAIL restart got=%b/%h/%b/%h exp=1/80000000/0/0", imem_req, imem_addr, out_valid, drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_double_redirect();
    test_hold_redirect();
    test_wrap_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
